// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter that shares one UART TX byte stream
//   i_clk/i_reset            clock, synchronous active-high reset
//   i_reqValid/Data/Last     per-requester byte stream (requester k on i_reqData[8k+7:8k])
//   o_reqReady               per-requester accept, only the granted requester can see it high
//   o_valid/o_data/i_ready   one-byte registered output stage toward uart_tx
//   o_grant/o_busy           current or last granted requester, high while a grant is locked
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_reqValid,
  input  logic [8*NUM_REQ-1:0] i_reqData,
  input  logic [NUM_REQ-1:0]   i_reqLast,
  output logic [NUM_REQ-1:0]   o_reqReady,
  output logic                 o_valid,
  output logic [7:0]           o_data,
  input  logic                 i_ready,
  output logic [2:0]           o_grant,
  output logic                 o_busy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t        state_q;
  logic [IW-1:0] grant_q, ptr_q, win_d, cand;
  logic [7:0]    burst_q, idle_q, data_q;
  logic          valid_q, locked, free, g_valid, xfer, release_d;
  // Scan from the farthest offset down to the pointer so the nearest valid index wins.
  always_comb begin
    win_d = ptr_q;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = (int'(ptr_q) + i >= NUM_REQ) ? IW'(int'(ptr_q) + i - NUM_REQ) : IW'(int'(ptr_q) + i);
      win_d = i_reqValid[cand] ? cand : win_d;
    end
  end
  assign locked     = state_q == LOCKED;
  assign free       = ~valid_q | i_ready;
  assign g_valid    = i_reqValid[grant_q];
  assign xfer       = locked & g_valid & free;
  assign release_d  = (xfer & (i_reqLast[grant_q] | (burst_q == 8'(MAX_BURST - 1))))
                    | (locked & ~g_valid & (idle_q == 8'(TIMEOUT - 1)));
  assign o_reqReady = (locked && free) ? NUM_REQ'(1) << grant_q : '0;
  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_grant    = 3'(grant_q);
  assign o_busy     = locked;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      idle_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // A new load takes precedence over the downstream draining the held byte.
      valid_q <= xfer | (valid_q & ~i_ready);
      if (xfer) data_q <= i_reqData[8*grant_q +: 8];
      if (!locked) begin
        if (|i_reqValid) begin
          state_q <= LOCKED;
          grant_q <= win_d;
          burst_q <= '0;
          idle_q  <= '0;
        end
      end else begin
        burst_q <= xfer ? burst_q + 8'd1 : burst_q;
        // Stall time only counts while the owner has nothing to offer; backpressure freezes it.
        idle_q  <= xfer ? '0 : (g_valid ? idle_q : idle_q + 8'd1);
        if (release_d) begin
          state_q <= IDLE;
          ptr_q   <= (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed bench with a cycle-level behavioural model
module tb_uart_tx_arbiter;
  localparam int NR = 4, MB = 16, TO = 64;
  logic clk = 0;
  always #5 clk = ~clk;
  logic i_reset = 1;
  logic [NR-1:0] i_reqValid, i_reqLast, o_reqReady;
  logic [8*NR-1:0] i_reqData;
  logic o_valid, i_ready, o_busy;
  logic [7:0] o_data;
  logic [2:0] o_grant;
  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_reqValid(i_reqValid), .i_reqData(i_reqData),
    .i_reqLast(i_reqLast), .o_reqReady(o_reqReady), .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready), .o_grant(o_grant), .o_busy(o_busy));
  int total = 0, bad = 0;
  logic [8:0] q [NR][$];
  logic [7:0] out_log [$];
  logic [NR-1:0] acc = '0, mute = '0, exp_rdy;
  int rdy_pct = 100, gap_pct = 0;
  int m_owner, m_ptr, m_cnt, m_idle;
  bit m_locked, m_ov, m_free, m_found;
  logic [7:0] m_od;

  // requester sources and downstream sink
  initial begin
    i_reqValid = '0; i_reqLast = '0; i_reqData = '0; i_ready = 1;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < NR; k++) begin
        if (acc[k] && q[k].size() > 0) void'(q[k].pop_front());
        i_reqValid[k] = q[k].size() > 0 && !mute[k] && $urandom_range(99) >= gap_pct;
        i_reqData[8*k +: 8] = q[k].size() > 0 ? q[k][0][7:0] : 8'h00;
        i_reqLast[k] = q[k].size() > 0 && q[k][0][8];
      end
      i_ready = $urandom_range(99) < rdy_pct;
    end
  end

  // behavioural model: grant by rotating search, lock until last/burst/timeout, one held byte
  initial forever begin
    @(negedge clk);
    if (i_reset) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_idle = 0; m_ov = 0; m_od = 0; acc = '0;
    end else begin
      m_free = !m_ov || i_ready;
      exp_rdy = (m_locked && m_free) ? NR'(1) << m_owner : '0;
      total += 4;
      if (o_busy !== m_locked) begin bad++; $display("FAIL model_busy t=%0t got=%0d exp=%0d", $time, o_busy, m_locked); end
      if (o_grant !== 3'(m_owner)) begin bad++; $display("FAIL model_grant t=%0t got=%0d exp=%0d", $time, o_grant, m_owner); end
      if (o_valid !== m_ov) begin bad++; $display("FAIL model_valid t=%0t got=%0d exp=%0d", $time, o_valid, m_ov); end
      if (o_reqReady !== exp_rdy) begin bad++; $display("FAIL model_ready t=%0t got=%b exp=%b", $time, o_reqReady, exp_rdy); end
      if (m_ov) begin
        total++;
        if (o_data !== m_od) begin bad++; $display("FAIL model_data t=%0t got=%h exp=%h", $time, o_data, m_od); end
      end
      acc = i_reqValid & exp_rdy;
      if (o_valid && i_ready) out_log.push_back(o_data);
      if (!m_locked) begin
        if (m_ov && i_ready) m_ov = 0;
        if (|i_reqValid) begin
          m_found = 0;
          for (int i = 0; i < NR; i++)
            if (!m_found && i_reqValid[(m_ptr + i) % NR]) begin m_found = 1; m_owner = (m_ptr + i) % NR; end
          m_locked = 1; m_cnt = 0; m_idle = 0;
        end
      end else if (i_reqValid[m_owner] && m_free) begin
        m_ov = 1; m_od = i_reqData[8*m_owner +: 8]; m_cnt++; m_idle = 0;
        if (i_reqLast[m_owner] || m_cnt == MB) begin m_locked = 0; m_ptr = (m_owner + 1) % NR; end
      end else begin
        if (m_ov && i_ready) m_ov = 0;
        if (!i_reqValid[m_owner]) begin
          m_idle++;
          if (m_idle == TO) begin m_locked = 0; m_ptr = (m_owner + 1) % NR; end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic push(input int k, input logic last, input logic [7:0] d);
    q[k].push_back({last, d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    for (int k = 0; k < NR; k++) q[k].delete();
    mute = '0; rdy_pct = 100; gap_pct = 0;
    @(posedge clk); #2; i_reset = 1; out_log.delete();
    repeat (2) @(posedge clk);
    #2; i_reset = 0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int max, input string nm);
    int n = 0, p;
    p = 1;
    while ((p > 0 || o_busy || o_valid) && n < max) begin
      @(negedge clk); n++;
      p = 0;
      for (int k = 0; k < NR; k++) p += q[k].size();
    end
    total++;
    if (n >= max) begin bad++; $display("FAIL %s_drain got=%0d cycles exp<%0d", nm, n, max); end
  endtask

  task automatic wait_valid(input int max, input string nm);
    int n = 0;
    while (!o_valid && n < max) begin @(negedge clk); n++; end
    total++;
    if (n >= max) begin bad++; $display("FAIL %s_wait_valid got=%0d cycles exp<%0d", nm, n, max); end
  endtask

  task automatic test_reset();
    do_reset();
    total += 5;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", o_valid); end
    if (o_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", o_data); end
    if (o_grant !== 3'd0) begin bad++; $display("FAIL reset_grant got=%0d exp=0", o_grant); end
    if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", o_busy); end
    if (o_reqReady !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", o_reqReady); end
  endtask

  task automatic test_single();
    do_reset();
    push(1, 0, 8'h41); push(1, 0, 8'h42); push(1, 1, 8'h43);
    @(negedge clk);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL single_c0_busy got=%0d exp=0", o_busy); end
    @(negedge clk);
    total += 3;
    if (o_grant !== 3'd1) begin bad++; $display("FAIL single_c1_grant got=%0d exp=1", o_grant); end
    if (o_busy !== 1'b1) begin bad++; $display("FAIL single_c1_busy got=%0d exp=1", o_busy); end
    if (o_reqReady !== 4'b0010) begin bad++; $display("FAIL single_c1_ready got=%b exp=0010", o_reqReady); end
    @(negedge clk);
    total++; if (!o_valid || o_data !== 8'h41) begin bad++; $display("FAIL single_c2 got=%0d/%h exp=1/41", o_valid, o_data); end
    @(negedge clk);
    total++; if (!o_valid || o_data !== 8'h42) begin bad++; $display("FAIL single_c3 got=%0d/%h exp=1/42", o_valid, o_data); end
    @(negedge clk);
    total += 2;
    if (!o_valid || o_data !== 8'h43) begin bad++; $display("FAIL single_c4 got=%0d/%h exp=1/43", o_valid, o_data); end
    if (o_busy !== 1'b0) begin bad++; $display("FAIL single_c4_busy got=%0d exp=0", o_busy); end
    push(0, 1, 8'h01); push(2, 1, 8'h21);
    @(negedge clk); @(negedge clk);
    total++; if (o_grant !== 3'd2) begin bad++; $display("FAIL single_ptr2_grant got=%0d exp=2", o_grant); end
    wait_drain(50, "single");
  endtask

  task automatic test_rr();
    logic [7:0] e [$] = '{8'h01, 8'h02, 8'h21, 8'h22, 8'h31, 8'h03};
    do_reset();
    push(0, 0, 8'h01); push(0, 1, 8'h02); push(2, 0, 8'h21); push(2, 1, 8'h22);
    wait_drain(50, "rr1");
    push(3, 1, 8'h31); push(0, 1, 8'h03);
    wait_drain(50, "rr2");
    total++; if (out_log.size() != e.size()) begin bad++; $display("FAIL rr_count got=%0d exp=%0d", out_log.size(), e.size()); end
    for (int i = 0; i < e.size() && i < out_log.size(); i++) begin
      total++; if (out_log[i] !== e[i]) begin bad++; $display("FAIL rr_byte%0d got=%h exp=%h", i, out_log[i], e[i]); end
    end
  endtask

  task automatic test_burst();
    logic [7:0] e [$];
    do_reset();
    for (int i = 0; i < 20; i++) push(3, i == 19, 8'(8'h80 + i));
    @(negedge clk);
    push(1, 1, 8'h11);
    wait_drain(200, "burst");
    for (int i = 0; i < 16; i++) e.push_back(8'(8'h80 + i));
    e.push_back(8'h11);
    for (int i = 16; i < 20; i++) e.push_back(8'(8'h80 + i));
    total++; if (out_log.size() != e.size()) begin bad++; $display("FAIL burst_count got=%0d exp=%0d", out_log.size(), e.size()); end
    for (int i = 0; i < e.size() && i < out_log.size(); i++) begin
      total++; if (out_log[i] !== e[i]) begin bad++; $display("FAIL burst_byte%0d got=%h exp=%h", i, out_log[i], e[i]); end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    push(0, 0, 8'h01);
    wait_valid(10, "timeout");
    push(2, 1, 8'h21);
    while (o_busy && n < 200) begin n++; @(negedge clk); end
    total++; if (n != TO) begin bad++; $display("FAIL timeout_len got=%0d exp=%0d", n, TO); end
    @(negedge clk);
    total += 2;
    if (o_grant !== 3'd2) begin bad++; $display("FAIL timeout_next_grant got=%0d exp=2", o_grant); end
    if (o_busy !== 1'b1) begin bad++; $display("FAIL timeout_next_busy got=%0d exp=1", o_busy); end
    wait_drain(50, "timeout");
    total++;
    if (out_log.size() != 2 || out_log[0] !== 8'h01 || out_log[1] !== 8'h21) begin
      bad++; $display("FAIL timeout_log got=%0d bytes exp=2 bytes 01,21", out_log.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_pct = 0;
    for (int i = 0; i < 5; i++) push(2, i == 4, 8'(8'h21 + i));
    wait_valid(10, "bp");
    for (int c = 0; c < 70; c++) begin
      total += 4;
      if (o_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%0d exp=1", c, o_valid); end
      if (o_data !== 8'h21) begin bad++; $display("FAIL bp_data c=%0d got=%h exp=21", c, o_data); end
      if (o_reqReady !== 4'b0) begin bad++; $display("FAIL bp_ready c=%0d got=%b exp=0000", c, o_reqReady); end
      if (o_busy !== 1'b1) begin bad++; $display("FAIL bp_busy c=%0d got=%0d exp=1", c, o_busy); end
      @(negedge clk);
    end
    rdy_pct = 100;
    wait_drain(50, "bp");
    total++; if (out_log.size() != 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", out_log.size()); end
    for (int i = 0; i < 5 && i < out_log.size(); i++) begin
      total++; if (out_log[i] !== 8'(8'h21 + i)) begin bad++; $display("FAIL bp_byte%0d got=%h exp=%h", i, out_log[i], 8'(8'h21 + i)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(2, 1, 8'h21);
    wait_drain(50, "rmid_pre");
    for (int i = 0; i < 8; i++) push(1, i == 7, 8'(8'h11 + i));
    wait_valid(10, "rmid");
    @(posedge clk); #2; i_reset = 1; q[1].delete(); out_log.delete();
    @(posedge clk); #2; i_reset = 0;
    @(negedge clk);
    total += 5;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0d exp=0", o_valid); end
    if (o_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h exp=00", o_data); end
    if (o_grant !== 3'd0) begin bad++; $display("FAIL rmid_grant got=%0d exp=0", o_grant); end
    if (o_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0d exp=0", o_busy); end
    if (o_reqReady !== 4'b0) begin bad++; $display("FAIL rmid_ready got=%b exp=0000", o_reqReady); end
    push(3, 1, 8'h33); push(1, 1, 8'h13);
    @(negedge clk); @(negedge clk);
    total++; if (o_grant !== 3'd1) begin bad++; $display("FAIL rmid_fresh_grant got=%0d exp=1", o_grant); end
    wait_drain(50, "rmid");
    total++;
    if (out_log.size() != 2 || out_log[0] !== 8'h13 || out_log[1] !== 8'h33) begin
      bad++; $display("FAIL rmid_log got=%0d bytes exp=2 bytes 13,33", out_log.size());
    end
  endtask

  task automatic test_random();
    int nxt [NR];
    int k;
    do_reset();
    rdy_pct = 70; gap_pct = 25;
    for (int r = 0; r < NR; r++) begin
      nxt[r] = 0;
      for (int n = 0; n < 25; n++) push(r, $urandom_range(4) == 0, {2'(r), 6'(n)});
    end
    wait_drain(8000, "random");
    total++; if (out_log.size() != NR * 25) begin bad++; $display("FAIL random_count got=%0d exp=%0d", out_log.size(), NR * 25); end
    foreach (out_log[i]) begin
      k = int'(out_log[i][7:6]);
      total++;
      if (out_log[i][5:0] !== 6'(nxt[k])) begin bad++; $display("FAIL random_order req%0d got=%0d exp=%0d", k, out_log[i][5:0], nxt[k]); end
      nxt[k]++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_burst();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
